nec_int_ctrl: RTL and testbench

Single-chip µPD71059-style 8-input interrupt controller. It sits directly upstream of the V33 bus control unit. It resolves the `ir` request lines into one `intreq` level and services the two-cycle interrupt-acknowledge sequence that the bus control unit runs. During the second acknowledge cycle it returns the 8-bit vector on the bus. The CPU programs and inspects it through a two-address I/O port.

---
 rtl/nec_int_ctrl.sv | 93 +++++++++
 tb/tb_nec_int_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/nec_int_ctrl.sv
// nec_int_ctrl: 8-input uPD71059-style interrupt controller with ICW/OCW port and two-cycle vectored acknowledge
module nec_int_ctrl #(
  parameter int EDGE_SYNC = 1
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       ce,
  input  logic       cs,
  input  logic       a0,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] ir,
  input  logic       inta,
  output logic       intreq
);
  typedef enum logic [1:0] {ICW2, ICW3, ICW4, READY} init_t;
  init_t st, st_n;
  logic [7:0] irr, isr, imr, hist, s0, s1, sync, pend;
  logic [7:0] irr_n, isr_n, imr_n;
  logic [4:0] vbase, vbase_n;
  logic [2:0] ack_lvl, ack_lvl_n;
  logic [1:0] rsel, rsel_n;
  logic [3:0] plow, elow;
  logic ltim, sngl, ic4_req, aeoi, ack_ph, spur;
  logic ltim_n, sngl_n, ic4_req_n, aeoi_n, ack_ph_n, spur_n;
  function automatic logic [3:0] low(input logic [7:0] v);
    low = 4'd8;
    for (int i = 7; i >= 0; i--) if (v[i]) low = 4'(i);
  endfunction
  assign sync = (EDGE_SYNC != 0) ? s1 : s0;
  assign pend = irr & ~imr;
  assign plow = low(pend);
  assign dout = ack_ph ? {vbase, ack_lvl} :
                (cs && rd) ? (a0 ? imr : rsel == 2'b11 ? isr : rsel == 2'b10 ? irr : 8'h00) : 8'h00;
  // acknowledge first, then request capture, then the CPU write so ICW1 overrides everything
  always_comb begin
    st_n = st; irr_n = irr; isr_n = isr; imr_n = imr; vbase_n = vbase;
    ack_lvl_n = ack_lvl; rsel_n = rsel; ltim_n = ltim; sngl_n = sngl;
    ic4_req_n = ic4_req; aeoi_n = aeoi; ack_ph_n = ack_ph; spur_n = spur;
    if (inta && !ack_ph) begin
      ack_ph_n = 1'b1;
      spur_n = plow[3];
      ack_lvl_n = plow[3] ? 3'd7 : plow[2:0];
      if (!plow[3]) begin
        isr_n[plow[2:0]] = 1'b1;
        if (!ltim) irr_n[plow[2:0]] = 1'b0;
      end
    end else if (inta) begin
      ack_ph_n = 1'b0;
      if (aeoi && !spur) isr_n[ack_lvl] = 1'b0;
    end
    irr_n = ltim ? sync : irr_n | (sync & ~hist);
    elow = low(isr_n);
    if (cs && wr) begin
      if (!a0 && din[4]) begin
        ltim_n = din[3]; sngl_n = din[1]; ic4_req_n = din[0];
        irr_n = 8'h00; isr_n = 8'h00; imr_n = 8'h00; ack_ph_n = 1'b0;
        st_n = ICW2;
      end else if (st == ICW2 && a0) begin
        vbase_n = din[7:3];
        st_n = !sngl ? ICW3 : ic4_req ? ICW4 : READY;
      end else if (st == ICW3 && a0) begin
        st_n = ic4_req ? ICW4 : READY;
      end else if (st == ICW4 && a0) begin
        aeoi_n = din[1];
        st_n = READY;
      end else if (st == READY && a0) begin
        imr_n = din;
      end else if (st == READY && !din[3]) begin
        if (din[7:5] == 3'b001 && !elow[3]) isr_n[elow[2:0]] = 1'b0;
        if (din[7:5] == 3'b011) isr_n[din[2:0]] = 1'b0;
      end else if (st == READY && din[1]) begin
        rsel_n = din[1:0];
      end
    end
  end
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      st <= READY; irr <= '0; isr <= '0; imr <= 8'hFF; vbase <= '0;
      ack_lvl <= '0; rsel <= 2'b10; ltim <= 1'b0; sngl <= 1'b0; ic4_req <= 1'b0;
      aeoi <= 1'b0; ack_ph <= 1'b0; spur <= 1'b0; intreq <= 1'b0;
      s0 <= '0; s1 <= '0; hist <= '0;
    end else if (ce) begin
      st <= st_n; irr <= irr_n; isr <= isr_n; imr <= imr_n; vbase <= vbase_n;
      ack_lvl <= ack_lvl_n; rsel <= rsel_n; ltim <= ltim_n; sngl <= sngl_n;
      ic4_req <= ic4_req_n; aeoi <= aeoi_n; ack_ph <= ack_ph_n; spur <= spur_n;
      intreq <= !plow[3] && plow < low(isr);
      s0 <= ir; s1 <= s0; hist <= sync;
    end
  end
endmodule

// File: tb/tb_nec_int_ctrl.sv
// tb_nec_int_ctrl: scoreboard bench for nec_int_ctrl programming, nesting, EOI, spurious ack and reset
module tb_nec_int_ctrl;
  logic clk = 0, n_reset = 0, ce = 1, cs = 0, a0 = 0, wr = 0, rd = 0, inta = 0;
  logic [7:0] din = 0, ir = 0, dout;
  logic intreq;
  int errors = 0, checks = 0;
  typedef struct {string tag; logic [7:0] v;} exp_t;
  exp_t sb[$];
  nec_int_ctrl dut (.clk(clk), .n_reset(n_reset), .ce(ce), .cs(cs), .a0(a0), .wr(wr),
                    .rd(rd), .din(din), .dout(dout), .ir(ir), .inta(inta), .intreq(intreq));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask
  task automatic push(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag; e.v = v;
    sb.push_back(e);
  endtask
  task automatic observe(input logic [7:0] got);
    exp_t e;
    e = sb.pop_front();
    chk(e.tag, got, e.v);
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr_reg(input logic a, input logic [7:0] d);
    cs = 1; wr = 1; a0 = a; din = d;
    tick();
    cs = 0; wr = 0;
  endtask
  task automatic rd_chk(input logic a, input string tag, input logic [7:0] e);
    push(tag, e);
    cs = 1; rd = 1; a0 = a;
    #1 observe(dout);
    cs = 0; rd = 0;
    #1;
  endtask
  task automatic vec_chk(input string tag, input logic [7:0] e);
    push(tag, e);
    #1 observe(dout);
  endtask
  task automatic irq_chk(input string tag, input logic e);
    push(tag, {7'b0, e});
    observe({7'b0, intreq});
  endtask
  task automatic wait_irq(input string tag);
    for (int n = 0; n < 10 && !intreq; n++) tick();
    irq_chk(tag, 1'b1);
  endtask
  task automatic pulse_inta;
    inta = 1;
    tick();
    inta = 0;
  endtask
  initial begin
    #3;
    irq_chk("rst_intreq", 1'b0);
    vec_chk("rst_dout", 8'h00);
    tick(2);
    n_reset = 1;
    tick();
    rd_chk(1, "rst_imr", 8'hFF);
    rd_chk(0, "rst_irr", 8'h00);
    wr_reg(0, 8'h13); wr_reg(1, 8'h40); wr_reg(1, 8'h03); wr_reg(1, 8'hFE);
    rd_chk(1, "ocw1_imr", 8'hFE);
    ir = 8'h01; tick(2); ir = 8'h00;
    wait_irq("ir0_intreq");
    pulse_inta();
    vec_chk("vec_ir0", 8'h40);
    tick(2);
    irq_chk("intreq_after_ack", 1'b0);
    vec_chk("vec_ir0_hold", 8'h40);
    pulse_inta();
    wr_reg(0, 8'h0B);
    rd_chk(0, "aeoi_isr", 8'h00);
    vec_chk("idle_dout", 8'h00);
    wr_reg(0, 8'h13); wr_reg(1, 8'h40); wr_reg(1, 8'h01);
    ir = 8'h08;
    wait_irq("ir3_intreq");
    pulse_inta();
    vec_chk("vec_ir3", 8'h43);
    pulse_inta();
    wr_reg(0, 8'h0B);
    rd_chk(0, "isr_ir3", 8'h08);
    ir = 8'h28; tick(6);
    irq_chk("ir5_blocked", 1'b0);
    ir = 8'h2A;
    wait_irq("ir1_nests");
    pulse_inta();
    vec_chk("vec_ir1", 8'h41);
    pulse_inta();
    rd_chk(0, "isr_nested", 8'h0A);
    wr_reg(0, 8'h20);
    rd_chk(0, "nsEOI_isr", 8'h08);
    wr_reg(0, 8'h0A);
    rd_chk(0, "irr_pend5", 8'h20);
    wr_reg(0, 8'h63);
    wr_reg(0, 8'h0B);
    rd_chk(0, "sEOI_isr", 8'h00);
    wait_irq("ir5_intreq");
    wr_reg(1, 8'hFF); tick(3);
    irq_chk("masked_intreq", 1'b0);
    pulse_inta();
    vec_chk("vec_spurious", 8'h47);
    pulse_inta();
    rd_chk(0, "spur_isr", 8'h00);
    wr_reg(0, 8'h0A);
    rd_chk(0, "spur_irr", 8'h20);
    wr_reg(1, 8'h00);
    wait_irq("unmask_intreq");
    pulse_inta();
    vec_chk("vec_ir5", 8'h45);
    wr_reg(0, 8'h13);
    vec_chk("icw1_abort", 8'h00);
    wr_reg(1, 8'h40); wr_reg(1, 8'h03);
    wr_reg(0, 8'h0A);
    rd_chk(0, "reinit_irr", 8'h00);
    wr_reg(0, 8'h0B);
    rd_chk(0, "reinit_isr", 8'h00);
    rd_chk(1, "reinit_imr", 8'h00);
    ce = 0; wr_reg(1, 8'h33); ce = 1;
    rd_chk(1, "ce_gate_imr", 8'h00);
    ir = 8'h00; tick(4);
    ir = 8'h40;
    wait_irq("ir6_intreq");
    pulse_inta();
    vec_chk("vec_ir6", 8'h46);
    #1 n_reset = 0;
    #1 irq_chk("async_intreq", 1'b0);
    vec_chk("async_dout", 8'h00);
    #1 n_reset = 1;
    tick();
    rd_chk(1, "async_imr", 8'hFF);
    tick(6);
    irq_chk("post_rst_intreq", 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
